// File: rtl/sr_ff_bank_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sr_ff_bank_arbiter                                            |
// | Function : round-robin shared access to a bank of reset-less S/R flops   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sr_ff_bank_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int NUM_FF  = 8,
   parameter int IDX_W   = 3,
   parameter int REQ_W   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       i_req_valid,
   output logic [NUM_REQ-1:0]       o_req_ready,
   input  logic [2*NUM_REQ-1:0]     i_req_op,
   input  logic [IDX_W*NUM_REQ-1:0] i_req_idx,
   output logic [NUM_FF-1:0]        o_ff_S,
   output logic [NUM_FF-1:0]        o_ff_R,
   input  logic [NUM_FF-1:0]        i_ff_q,
   output logic                     o_done_valid,
   output logic [REQ_W-1:0]         o_done_req,
   output logic                     o_done_q,
   output logic                     o_done_err,
   output logic                     o_busy
);

   typedef enum logic [2:0] {
      ST_INIT     = 3'd0,
      ST_INIT_CLR = 3'd1,
      ST_IDLE     = 3'd2,
      ST_DRIVE    = 3'd3,
      ST_CHECK    = 3'd4
   } state_t;

   localparam logic [1:0] c_OP_RST = 2'b01;
   localparam logic [1:0] c_OP_SET = 2'b10;
   localparam logic [1:0] c_OP_ILL = 2'b11;

   state_t              r_state;
   logic [REQ_W-1:0]    r_rr_ptr;
   logic [REQ_W-1:0]    r_id;
   logic [1:0]          r_op;
   logic [IDX_W-1:0]    r_idx;
   logic                r_flag;
   logic [NUM_FF-1:0]   r_ff_S;
   logic [NUM_FF-1:0]   r_ff_R;
   logic                r_done_valid;
   logic [REQ_W-1:0]    r_done_req;
   logic                r_done_q;
   logic                r_done_err;

   state_t              w_state_nxt;
   logic [REQ_W-1:0]    w_rr_nxt;
   logic                w_accept;
   logic                w_found;
   logic [REQ_W-1:0]    w_gnt;
   int                  w_j;
   logic [1:0]          w_g_op;
   logic [IDX_W-1:0]    w_g_idx;
   logic [NUM_FF-1:0]   w_g_hot;
   logic [NUM_FF-1:0]   w_r_hot;
   logic                w_q_sel;
   logic [NUM_FF-1:0]   w_S_nxt;
   logic [NUM_FF-1:0]   w_R_nxt;
   logic                w_done_valid_nxt;
   logic [REQ_W-1:0]    w_done_req_nxt;
   logic                w_done_q_nxt;
   logic                w_done_err_nxt;

   // Rotating priority search starting at r_rr_ptr
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_j = (int'(r_rr_ptr) + k) % NUM_REQ;
         if (!w_found && i_req_valid[w_j]) begin
            w_found = 1'b1;
            w_gnt   = REQ_W'(w_j);
         end
      end
   end

   // Index decode doubles as range check: no hot bit means out of range
   always_comb begin
      w_g_op  = i_req_op[2*int'(w_gnt) +: 2];
      w_g_idx = i_req_idx[IDX_W*int'(w_gnt) +: IDX_W];
      w_g_hot = '0;
      w_r_hot = '0;
      for (int i = 0; i < NUM_FF; i++) begin
         if (w_g_idx == IDX_W'(i)) w_g_hot[i] = 1'b1;
         if (r_idx == IDX_W'(i))   w_r_hot[i] = 1'b1;
      end
      w_q_sel = |(i_ff_q & w_r_hot);
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_rr_nxt         = r_rr_ptr;
      w_accept         = 1'b0;
      o_req_ready      = '0;
      w_S_nxt          = '0;
      w_R_nxt          = '0;
      w_done_valid_nxt = 1'b0;
      w_done_req_nxt   = '0;
      w_done_q_nxt     = 1'b0;
      w_done_err_nxt   = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_R_nxt     = '1;
            w_state_nxt = ST_INIT_CLR;
         end
         ST_INIT_CLR: begin
            w_state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (w_found) begin
               o_req_ready[w_gnt] = 1'b1;
               w_accept           = 1'b1;
               w_rr_nxt           = REQ_W'((int'(w_gnt) + 1) % NUM_REQ);
               w_state_nxt        = ST_DRIVE;
               if (w_g_op == c_OP_SET) w_S_nxt = w_g_hot;
               if (w_g_op == c_OP_RST) w_R_nxt = w_g_hot;
            end
         end
         ST_DRIVE: begin
            w_state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            w_done_valid_nxt = 1'b1;
            w_done_req_nxt   = r_id;
            w_done_q_nxt     = w_q_sel;
            w_done_err_nxt   = r_flag
                             | ((r_op == c_OP_SET) & ~w_q_sel)
                             | ((r_op == c_OP_RST) &  w_q_sel);
            w_state_nxt      = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_INIT;
         r_rr_ptr     <= '0;
         r_id         <= '0;
         r_op         <= '0;
         r_idx        <= '0;
         r_flag       <= 1'b0;
         r_ff_S       <= '0;
         r_ff_R       <= '0;
         r_done_valid <= 1'b0;
         r_done_req   <= '0;
         r_done_q     <= 1'b0;
         r_done_err   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_rr_ptr     <= w_rr_nxt;
         r_ff_S       <= w_S_nxt;
         r_ff_R       <= w_R_nxt;
         r_done_valid <= w_done_valid_nxt;
         r_done_req   <= w_done_req_nxt;
         r_done_q     <= w_done_q_nxt;
         r_done_err   <= w_done_err_nxt;
         if (w_accept) begin
            r_id   <= w_gnt;
            r_op   <= w_g_op;
            r_idx  <= w_g_idx;
            r_flag <= (w_g_op == c_OP_ILL) | ~(|w_g_hot);
         end
      end
   end

   assign o_ff_S       = r_ff_S;
   assign o_ff_R       = r_ff_R;
   assign o_done_valid = r_done_valid;
   assign o_done_req   = r_done_req;
   assign o_done_q     = r_done_q;
   assign o_done_err   = r_done_err;
   assign o_busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
